// File: rtl/fp_conv_pkg.sv
// fp_conv_pkg: shared types and constants for the 12-bit linear to
// sign/exponent/significand converter (value = F * 2^E).
//   state_t   : sequencer states
//   IN_W/EXP_W/SIG_W : input, exponent and significand widths
//   MAX_EXP/MAX_SIG  : saturation values
//   CLAMP_MAG        : magnitude substituted for the most negative input
package fp_conv_pkg;

  localparam int unsigned IN_W  = 12;
  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;

  localparam logic [EXP_W-1:0] MAX_EXP   = 3'd7;
  localparam logic [SIG_W-1:0] MAX_SIG   = 4'd15;
  localparam logic [IN_W-1:0]  CLAMP_MAG = 12'h7FF;

  typedef enum logic [2:0] {
    IDLE,
    MAG,
    NORM,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp_conv_if.sv
// fp_conv_if: sample-in / result-out handshake bundle for fp_conv_seq.
//   in_valid/in_ready/D          : sample handshake (source -> converter)
//   out_valid/out_ready/S/E/F    : result handshake (converter -> consumer)
//   busy                         : converter is not idle
// Modports: master = source/consumer side, slave = converter side.
interface fp_conv_if;
  import fp_conv_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  D;
  logic             out_valid;
  logic             out_ready;
  logic             S;
  logic [EXP_W-1:0] E;
  logic [SIG_W-1:0] F;
  logic             busy;

  modport master (
    output in_valid, D, out_ready,
    input  in_ready, out_valid, S, E, F, busy
  );

  modport slave (
    input  in_valid, D, out_ready,
    output in_ready, out_valid, S, E, F, busy
  );

endinterface

// File: rtl/fp_round_unit.sv
// fp_round_unit: combinational rounding stage of the converter.
//   f : 4-bit truncated significand, r : first discarded bit, e : exponent
//   F : final significand, E : final exponent
// Build option FPCONV_ROUND_EN: defined -> round-half-up with exponent
// carry and saturation at E=7/F=15; undefined -> plain truncation.
module fp_round_unit
  import fp_conv_pkg::*;
(
  input  logic [SIG_W-1:0] f,
  input  logic             r,
  input  logic [EXP_W-1:0] e,
  output logic [SIG_W-1:0] F,
  output logic [EXP_W-1:0] E
);

`ifdef FPCONV_ROUND_EN
  logic [SIG_W:0] fr;

  always_comb begin
    fr = {1'b0, f} + {{SIG_W{1'b0}}, r};
    F  = fr[SIG_W-1:0];
    E  = e;
    // Carry out of the significand renormalises to 1000 with E+1,
    // unless the exponent is already at its ceiling.
    if (fr[SIG_W]) begin
      if (e == MAX_EXP) begin
        F = MAX_SIG;
        E = MAX_EXP;
      end else begin
        F = {1'b1, {(SIG_W-1){1'b0}}};
        E = e + 3'd1;
      end
    end
  end
`else
  logic unused_r;

  assign unused_r = r;
  assign F        = f;
  assign E        = e;
`endif

endmodule

// File: rtl/fp_conv_seq.sv
// fp_conv_seq: multi-cycle 12-bit two's-complement to S/E/F converter.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fp_conv_if.slave (sample handshake in, result handshake out,
//                busy status)
// Flow: IDLE -> MAG -> NORM (one shift per clock) -> ROUND -> DONE.
// Latency accept->out_valid is n+3 cycles, n = number of shifts (0..7).
// Build option FPCONV_ROUND_EN selects rounding in fp_round_unit.
module fp_conv_seq
  import fp_conv_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  fp_conv_if.slave  bus
);

  state_t           state;
  logic [IN_W-1:0]  mag;
  logic [IN_W-1:0]  mag_abs;
  logic [EXP_W-1:0] e;
  logic             s_q;
  logic [EXP_W-1:0] e_q;
  logic [SIG_W-1:0] f_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic             busy_q;
  logic [SIG_W-1:0] rnd_f;
  logic [EXP_W-1:0] rnd_e;

  // The raw sample is parked in the magnitude register on capture and
  // converted in place during MAG; -2048 has no positive 12-bit twin.
  always_comb begin
    if (mag == {1'b1, {(IN_W-1){1'b0}}})
      mag_abs = CLAMP_MAG;
    else if (mag[IN_W-1])
      mag_abs = -mag;
    else
      mag_abs = mag;
  end

  fp_round_unit u_round (
    .f (mag[10:7]),
    .r (mag[6]),
    .e (e),
    .F (rnd_f),
    .E (rnd_e)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mag         <= '0;
      e           <= '0;
      s_q         <= 1'b0;
      e_q         <= '0;
      f_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mag        <= bus.D;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state      <= MAG;
          end
        end
        MAG: begin
          s_q   <= mag[IN_W-1];
          mag   <= mag_abs;
          e     <= MAX_EXP;
          state <= NORM;
        end
        NORM: begin
          if (mag[10] || e == '0) begin
            state <= ROUND;
          end else begin
            mag <= {mag[IN_W-2:0], 1'b0};
            e   <= e - 3'd1;
          end
        end
        ROUND: begin
          e_q         <= rnd_e;
          f_q         <= rnd_f;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.E         = e_q;
  assign bus.F         = f_q;

endmodule

// File: tb/tb_fp_conv_seq.sv
// tb_fp_conv_seq: directed self-checking bench for fp_conv_seq.
// Expected S/E/F and latency come from an arithmetic model of the
// conversion (MSB position, shift-right, optional round-half-up),
// honouring FPCONV_ROUND_EN the same way the design does.
module tb_fp_conv_seq;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic prev_valid = 1'b0;
  logic expect_idle = 1'b0;

  fp_conv_if ifc ();

  fp_conv_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Value = F * 2^E: pick E from the MSB position of |D| (min 0),
  // F = |D| >> E, r = next lower bit.
  function automatic void model(input logic [11:0] d, output logic s, output logic [2:0] eo,
                                output logic [3:0] fo, output int n);
    int v, m, p, ex, f, r;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    if (m > 2047) m = 2047;
    p = -1;
    for (int i = 0; i < 11; i++) if (m >= (1 << i)) p = i;
    ex = (p > 3) ? p - 3 : 0;
    n  = 7 - ex;
    f  = m >> ex;
    r  = (ex > 0) ? ((m >> (ex - 1)) & 1) : 0;
`ifdef FPCONV_ROUND_EN
    f = f + r;
    if (f == 16) begin
      if (ex < 7) begin
        f  = 8;
        ex = ex + 1;
      end else begin
        f = 15;
      end
    end
`endif
    s  = d[11];
    eo = 3'(ex);
    fo = 4'(f);
  endfunction

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid  = 1'b0;
      expect_idle = 1'b0;
    end else begin
      chk("busy_vs_in_ready", 32'(ifc.busy), 32'(!ifc.in_ready));
      if (expect_idle) begin
        chk("idle_after_release", {30'd0, ifc.in_ready, ifc.out_valid}, 32'd2);
        expect_idle = 1'b0;
      end
      if (ifc.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=out_valid=1 expected=no_result (t=%0t)", $time);
        end else begin
          chk("S", 32'(ifc.S), 32'(exp_q[0].s));
          chk("E", 32'(ifc.E), 32'(exp_q[0].e));
          chk("F", 32'(ifc.F), 32'(exp_q[0].f));
          chk("in_ready_in_done", 32'(ifc.in_ready), 32'd0);
          if (!prev_valid) chk("latency_cycle", 32'(cyc), 32'(exp_q[0].due));
          if (ifc.out_ready) begin
            void'(exp_q.pop_front());
            expect_idle = 1'b1;
          end
        end
      end
      prev_valid = ifc.out_valid;
    end
  end

  task automatic send(input logic [11:0] d);
    int   t;
    logic s;
    logic [2:0] e;
    logic [3:0] f;
    int   n;
    t = 0;
    @(negedge clk);
    while (!ifc.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ifc.in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout actual=0 expected=1 (t=%0t)", $time);
      return;
    end
    model(d, s, e, f, n);
    exp_q.push_back('{s: s, e: e, f: f, due: cyc + 1 + n + 3});
    ifc.in_valid = 1'b1;
    ifc.D        = d;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.D        = 12'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL result_timeout actual=pending expected=drained (t=%0t)", $time);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pin(input logic [11:0] d, input logic es, input int ee, input int ef, input int en);
    logic s;
    logic [2:0] e;
    logic [3:0] f;
    int   n;
    model(d, s, e, f, n);
    chk("model_S", 32'(s), 32'(es));
    chk("model_E", 32'(e), 32'(ee));
    chk("model_F", 32'(f), 32'(ef));
    chk("model_n", 32'(n), 32'(en));
  endtask

  logic [11:0] vec [11] = '{12'h1A6, 12'h02E, 12'h0F8, 12'h7FF, 12'h800, 12'hFFF,
                            12'h400, 12'h3FF, 12'h00F, 12'h010, 12'hC00};

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.D         = '0;

    // Hand-computed anchors for the model
    pin(12'h1A6, 1'b0, 5, 13, 2);
    pin(12'hFFF, 1'b1, 0, 1, 7);
    pin(12'h000, 1'b0, 0, 0, 7);
`ifdef FPCONV_ROUND_EN
    pin(12'h02E, 1'b0, 2, 12, 5);
    pin(12'h0F8, 1'b0, 5, 8, 3);
    pin(12'h7FF, 1'b0, 7, 15, 0);
    pin(12'h800, 1'b1, 7, 15, 0);
`else
    pin(12'h02E, 1'b0, 2, 11, 5);
    pin(12'h0F8, 1'b0, 4, 15, 3);
    pin(12'h7FF, 1'b0, 7, 15, 0);
    pin(12'h800, 1'b1, 7, 15, 0);
`endif

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_out_valid_after", 32'(ifc.out_valid), 32'd0);
    chk("rst_SEF", {24'd0, ifc.S, ifc.E, ifc.F}, 32'd0);

    // Directed vectors, consumer always ready
    foreach (vec[i]) send(vec[i]);
    drain();

    // Backpressure: hold 20 cycles with a competing sample offered
    ifc.out_ready = 1'b0;
    send(12'h1A6);
    for (int t = 0; t < 50 && !ifc.out_valid; t++) @(negedge clk);
    chk("bp_valid_seen", 32'(ifc.out_valid), 32'd1);
    ifc.in_valid = 1'b1;
    ifc.D        = 12'h555;
    repeat (20) @(negedge clk);
    chk("bp_in_ready", 32'(ifc.in_ready), 32'd0);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    drain();

    // Reset during NORM discards the pending result
    send(12'h001);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("midrst_busy", 32'(ifc.busy), 32'd0);
    chk("midrst_SEF", {24'd0, ifc.S, ifc.E, ifc.F}, 32'd0);
    rst_n = 1'b1;
    send(12'h000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
